// File: rtl/three_input_oc_expander_if.sv
// Count-in / serial-bit-out handshake bundle for the ones-count expander.
// The expander itself sits on the slave side.
interface three_input_oc_expander_if #(
  parameter int WIDTH = 3
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt_in;
  logic          cnt_valid;
  logic          cnt_ready;
  logic          bit_out;
  logic          bit_valid;
  logic          bit_ready;
  logic          frame_start;
  logic          frame_end;
  logic          err_range;
  logic          busy;

  modport master (
    output cnt_in, cnt_valid, bit_ready,
    input  cnt_ready, bit_out, bit_valid, frame_start, frame_end, err_range, busy
  );

  modport slave (
    input  cnt_in, cnt_valid, bit_ready,
    output cnt_ready, bit_out, bit_valid, frame_start, frame_end, err_range, busy
  );
endinterface

// File: rtl/three_input_oc_expander.sv
// Expands a ones-count word into a WIDTH-bit thermometer frame (ones first),
// with a zero-bubble reload of the next count on the last bit of a frame.
module three_input_oc_expander #(
  parameter  int WIDTH = 3,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input logic                       clk,
  input logic                       rst_n,
  three_input_oc_expander_if.slave  bus
);

  localparam logic [CW-1:0] WMAX = CW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] idx, idx_nxt;
  logic [CW-1:0] cnt_reg, cnt_nxt;
  logic          err_reg, err_nxt;
  logic          cnt_rdy;
  logic          bit_vld;
  logic          bit_val;
  logic          fstart;
  logic          fend;

  function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] c);
    return (c > WMAX) ? WMAX : c;
  endfunction

  function automatic logic over_range(input logic [CW-1:0] c);
    return c > WMAX;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt_reg <= cnt_nxt;
      err_reg <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt_reg;
    err_nxt   = 1'b0;
    cnt_rdy   = 1'b0;
    bit_vld   = 1'b0;
    bit_val   = 1'b0;
    fstart    = 1'b0;
    fend      = 1'b0;
    case (state)
      IDLE: begin
        cnt_rdy = 1'b1;
        if (bus.cnt_valid) begin
          cnt_nxt   = clamp_cnt(bus.cnt_in);
          err_nxt   = over_range(bus.cnt_in);
          idx_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        bit_vld = 1'b1;
        bit_val = (idx < cnt_reg);
        fstart  = (idx == '0);
        fend    = (idx == LAST);
        if (bus.bit_ready) begin
          if (idx == LAST) begin
            // Last bit leaving: a waiting count is taken in the same cycle.
            cnt_rdy = 1'b1;
            idx_nxt = '0;
            if (bus.cnt_valid) begin
              cnt_nxt = clamp_cnt(bus.cnt_in);
              err_nxt = over_range(bus.cnt_in);
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            idx_nxt = idx + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cnt_ready stays low while reset is held so nothing is offered as accepted.
  assign bus.cnt_ready   = rst_n & cnt_rdy;
  assign bus.bit_valid   = bit_vld;
  assign bus.bit_out     = bit_val;
  assign bus.frame_start = fstart;
  assign bus.frame_end   = fend;
  assign bus.busy        = (state == SHIFT);
  assign bus.err_range   = err_reg;

endmodule
